// File: rtl/tbus_port_ctrl_if.sv
// Shared-bus port bundle: local transmit handshake, driver-cell pins, receive side.
// master = port controller, slave = the user/bus environment around it.
interface tbus_port_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] bus_out;
  logic             bus_en;
  logic [WIDTH-1:0] bus_in;
  logic             peer_drv;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             collide;

  modport master (
    input  tx_data, tx_valid, bus_in, peer_drv,
    output tx_ready, bus_out, bus_en, rx_data, rx_valid, collide
  );

  modport slave (
    output tx_data, tx_valid, bus_in, peer_drv,
    input  tx_ready, bus_out, bus_en, rx_data, rx_valid, collide
  );
endinterface

// File: rtl/tbus_port_ctrl.sv
// Half-duplex shared-bus port: arbitrates local transmit vs. remote drive with
// turnaround gaps, drives inverting tristate cells, captures peer words.
module tbus_port_ctrl #(
  parameter int WIDTH = 8,
  parameter int TURN  = 1
) (
  input  logic             clk,
  input  logic             rst,
  tbus_port_ctrl_if.master bus
);

  localparam logic [3:0] TURN_C = 4'(TURN);

  typedef enum logic [1:0] {IDLE, TURN_TX, DRIVE, TURN_RX} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] bus_out_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             bus_en_q;
  logic             rx_valid_q;
  logic             collide_q;

  // A peer seen while driving vetoes the word offered in that same cycle.
  assign bus.tx_ready = (state == DRIVE) && !bus.peer_drv;
  assign bus.bus_out  = bus_out_q;
  assign bus.bus_en   = bus_en_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.collide  = collide_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      bus_out_q  <= '1;
      bus_en_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      collide_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          bus_en_q <= 1'b0;
          if (bus.peer_drv) begin
            rx_data_q  <= bus.bus_in;
            rx_valid_q <= 1'b1;
          end else if (bus.tx_valid) begin
            if (TURN_C == 4'd0) begin
              state <= DRIVE;
            end else begin
              state <= TURN_TX;
              cnt   <= TURN_C;
            end
          end
        end
        TURN_TX: begin
          bus_en_q <= 1'b0;
          // Peer grabbed the bus first: back off, request is retried from IDLE.
          if (bus.peer_drv) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt <= 4'd1) begin
            state <= DRIVE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DRIVE: begin
          if (bus.peer_drv) begin
            collide_q <= 1'b1;
            bus_en_q  <= 1'b0;
            state     <= TURN_RX;
            cnt       <= TURN_C;
          end else if (bus.tx_valid) begin
            bus_out_q <= ~bus.tx_data;
            bus_en_q  <= 1'b1;
          end else begin
            bus_en_q <= 1'b0;
            state    <= TURN_RX;
            cnt      <= TURN_C;
          end
        end
        TURN_RX: begin
          bus_en_q <= 1'b0;
          // With zero turnaround this state still lasts a single cycle.
          if (cnt <= 4'd1) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= 4'd0;
          bus_en_q <= 1'b0;
        end
      endcase
    end
  end

  a_en_only_drive: assert property (@(posedge clk) disable iff (rst)
    bus_en_q |-> (state == DRIVE));
  a_no_en_rx: assert property (@(posedge clk) disable iff (rst)
    !(bus_en_q && rx_valid_q));

endmodule

// File: tb/tb_tbus_port_ctrl.sv
// Directed bench for tbus_port_ctrl: vector table on TURN=1 plus
// hand sequences for TURN=0, TURN=15 and asynchronous reset.
module tb_tbus_port_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pd, tv;
  logic [7:0] td, bi;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  tbus_port_ctrl_if #(.WIDTH(8)) if1 ();
  tbus_port_ctrl_if #(.WIDTH(8)) if0 ();
  tbus_port_ctrl_if #(.WIDTH(8)) if15 ();

  assign if1.peer_drv  = pd;  assign if1.tx_valid  = tv;
  assign if1.tx_data   = td;  assign if1.bus_in    = bi;
  assign if0.peer_drv  = pd;  assign if0.tx_valid  = tv;
  assign if0.tx_data   = td;  assign if0.bus_in    = bi;
  assign if15.peer_drv = pd;  assign if15.tx_valid = tv;
  assign if15.tx_data  = td;  assign if15.bus_in   = bi;

  tbus_port_ctrl #(.WIDTH(8), .TURN(1))  u1  (.clk(clk), .rst(rst), .bus(if1));
  tbus_port_ctrl #(.WIDTH(8), .TURN(0))  u0  (.clk(clk), .rst(rst), .bus(if0));
  tbus_port_ctrl #(.WIDTH(8), .TURN(15)) u15 (.clk(clk), .rst(rst), .bus(if15));

  // Output tuple: {tx_ready, bus_en, bus_out, rx_valid, rx_data, collide}
  function automatic logic [19:0] tup(input logic rdy, en, input logic [7:0] bo,
                                      input logic rv, input logic [7:0] rd, input logic col);
    return {rdy, en, bo, rv, rd, col};
  endfunction

  function automatic logic [19:0] o1();
    return {if1.tx_ready, if1.bus_en, if1.bus_out, if1.rx_valid, if1.rx_data, if1.collide};
  endfunction

  function automatic logic [19:0] o0();
    return {if0.tx_ready, if0.bus_en, if0.bus_out, if0.rx_valid, if0.rx_data, if0.collide};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pd = 1'b0; tv = 1'b0; td = 8'h00; bi = 8'h00;
    #1;
    chk("reset_hold", {12'h0, o1()}, {12'h0, tup(0, 0, 8'hFF, 0, 8'h00, 0)});
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       pd, tv;
    logic [7:0] td, bi;
    logic [19:0] exp;
  } vec_t;

  localparam int NV = 31;
  vec_t vt[NV];

  function automatic vec_t mk(input logic p, t, input logic [7:0] d, b,
                              input logic rdy, en, input logic [7:0] bo,
                              input logic rv, input logic [7:0] rd, input logic col);
    vec_t v;
    v.pd = p; v.tv = t; v.td = d; v.bi = b;
    v.exp = tup(rdy, en, bo, rv, rd, col);
    return v;
  endfunction

  int n;

  initial begin
    //           pd tv td     bi      rdy en out    rv rd     col
    vt[0]  = mk(0, 0, 8'h00, 8'h00,  0, 0, 8'hFF, 0, 8'h00, 0);
    vt[1]  = mk(0, 1, 8'hA5, 8'h00,  0, 0, 8'hFF, 0, 8'h00, 0);
    vt[2]  = mk(0, 1, 8'hA5, 8'h00,  0, 0, 8'hFF, 0, 8'h00, 0);
    vt[3]  = mk(0, 1, 8'hA5, 8'h00,  1, 0, 8'hFF, 0, 8'h00, 0);
    vt[4]  = mk(0, 0, 8'h00, 8'h00,  1, 1, 8'h5A, 0, 8'h00, 0);
    vt[5]  = mk(0, 0, 8'h00, 8'h00,  0, 0, 8'h5A, 0, 8'h00, 0);
    vt[6]  = mk(0, 1, 8'h01, 8'h00,  0, 0, 8'h5A, 0, 8'h00, 0);
    vt[7]  = mk(0, 1, 8'h01, 8'h00,  0, 0, 8'h5A, 0, 8'h00, 0);
    vt[8]  = mk(0, 1, 8'h01, 8'h00,  1, 0, 8'h5A, 0, 8'h00, 0);
    vt[9]  = mk(0, 1, 8'h02, 8'h00,  1, 1, 8'hFE, 0, 8'h00, 0);
    vt[10] = mk(0, 1, 8'h03, 8'h00,  1, 1, 8'hFD, 0, 8'h00, 0);
    vt[11] = mk(0, 0, 8'h00, 8'h00,  1, 1, 8'hFC, 0, 8'h00, 0);
    vt[12] = mk(0, 0, 8'h00, 8'h00,  0, 0, 8'hFC, 0, 8'h00, 0);
    vt[13] = mk(1, 0, 8'h00, 8'h3C,  0, 0, 8'hFC, 0, 8'h00, 0);
    vt[14] = mk(1, 0, 8'h00, 8'hC3,  0, 0, 8'hFC, 1, 8'h3C, 0);
    vt[15] = mk(0, 0, 8'h00, 8'h00,  0, 0, 8'hFC, 1, 8'hC3, 0);
    vt[16] = mk(1, 1, 8'h77, 8'h11,  0, 0, 8'hFC, 0, 8'hC3, 0);
    vt[17] = mk(1, 1, 8'h77, 8'h22,  0, 0, 8'hFC, 1, 8'h11, 0);
    vt[18] = mk(0, 1, 8'h77, 8'h00,  0, 0, 8'hFC, 1, 8'h22, 0);
    vt[19] = mk(0, 1, 8'h77, 8'h00,  0, 0, 8'hFC, 0, 8'h22, 0);
    vt[20] = mk(0, 1, 8'h77, 8'h00,  1, 0, 8'hFC, 0, 8'h22, 0);
    vt[21] = mk(1, 1, 8'h66, 8'h00,  0, 1, 8'h88, 0, 8'h22, 0);
    vt[22] = mk(1, 1, 8'h66, 8'hAA,  0, 0, 8'h88, 0, 8'h22, 1);
    vt[23] = mk(0, 0, 8'h00, 8'h00,  0, 0, 8'h88, 0, 8'h22, 1);
    vt[24] = mk(0, 1, 8'h44, 8'h00,  0, 0, 8'h88, 0, 8'h22, 1);
    vt[25] = mk(1, 1, 8'h44, 8'h99,  0, 0, 8'h88, 0, 8'h22, 1);
    vt[26] = mk(0, 1, 8'h44, 8'h00,  0, 0, 8'h88, 0, 8'h22, 1);
    vt[27] = mk(0, 1, 8'h44, 8'h00,  0, 0, 8'h88, 0, 8'h22, 1);
    vt[28] = mk(0, 1, 8'h44, 8'h00,  1, 0, 8'h88, 0, 8'h22, 1);
    vt[29] = mk(0, 0, 8'h00, 8'h00,  1, 1, 8'hBB, 0, 8'h22, 1);
    vt[30] = mk(0, 0, 8'h00, 8'h00,  0, 0, 8'hBB, 0, 8'h22, 1);

    // TURN=1: vector table
    do_reset();
    for (int i = 0; i < NV; i++) begin
      pd = vt[i].pd; tv = vt[i].tv; td = vt[i].td; bi = vt[i].bi;
      #2;
      chk($sformatf("t1_vec%0d", i), {12'h0, o1()}, {12'h0, vt[i].exp});
      cyc();
    end

    // Async reset mid-DRIVE while COLLIDE and RX_DATA are non-zero
    pd = 1'b0; tv = 1'b1; td = 8'h12;
    cyc(); cyc(); cyc();
    #2;
    chk("pre_rst_drive", {12'h0, o1()}, {12'h0, tup(1, 1, 8'hED, 0, 8'h22, 1)});
    rst = 1'b1;
    #1;
    chk("async_rst", {12'h0, o1()}, {12'h0, tup(0, 0, 8'hFF, 0, 8'h00, 0)});
    cyc();
    rst = 1'b0; tv = 1'b0;
    #2;
    chk("post_rst", {12'h0, o1()}, {12'h0, tup(0, 0, 8'hFF, 0, 8'h00, 0)});

    // TURN=0: straight to DRIVE, single-cycle TURN_RX
    do_reset();
    tv = 1'b1; td = 8'h5A; #2;
    chk("t0_c0", {12'h0, o0()}, {12'h0, tup(0, 0, 8'hFF, 0, 8'h00, 0)});
    cyc(); #2;
    chk("t0_c1", {12'h0, o0()}, {12'h0, tup(1, 0, 8'hFF, 0, 8'h00, 0)});
    cyc(); tv = 1'b0; #2;
    chk("t0_c2", {12'h0, o0()}, {12'h0, tup(1, 1, 8'hA5, 0, 8'h00, 0)});
    cyc(); #2;
    chk("t0_c3", {12'h0, o0()}, {12'h0, tup(0, 0, 8'hA5, 0, 8'h00, 0)});
    cyc(); pd = 1'b1; bi = 8'h42; #2;
    chk("t0_c4", {12'h0, o0()}, {12'h0, tup(0, 0, 8'hA5, 0, 8'h00, 0)});
    cyc(); pd = 1'b0; #2;
    chk("t0_c5", {12'h0, o0()}, {12'h0, tup(0, 0, 8'hA5, 1, 8'h42, 0)});

    // TURN=15: measure both turnarounds
    do_reset();
    tv = 1'b1; td = 8'h3C;
    n = 0;
    #1;
    while (!if15.tx_ready && n < 40) begin cyc(); n++; end
    chk("t15_tx_turn", n, 16);
    cyc(); tv = 1'b0; #1;
    chk("t15_drive", {if15.bus_en, if15.bus_out}, {1'b1, 8'hC3});
    cyc(); pd = 1'b1; bi = 8'h5E;
    n = 0;
    #1;
    while (!if15.rx_valid && n < 40) begin cyc(); n++; end
    chk("t15_rx_turn", n, 16);
    chk("t15_rx", {if15.rx_data, if15.collide, if15.bus_en}, {8'h5E, 1'b0, 1'b0});
    pd = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
